eb_fifo_rd_stage: RTL

Read-side stage that sits directly downstream of the FIFO controller. It consumes the controller's read handshake and the synchronous RAM's read data, which arrives one cycle after each read. It presents the data to the next elastic stage as a registered req/ack stream with its own data bus. A 2-entry landing buffer with credit-based read issue absorbs the RAM latency, so the stage sustains one word per cycle with no overrun and no bubble in steady state.

---
 rtl/eb_pkg.sv | 8 +
 rtl/eb_buf2.sv | 46 ++++
 rtl/eb_fifo_rd_stage.sv | 53 +++++
 3 files changed

// File: rtl/eb_pkg.sv
// Shared types and constants for the elastic-buffer read stage.
package eb_pkg;

    typedef logic [1:0] occ_t;

    localparam int EB_RD_DEPTH = 2;

endpackage

// File: rtl/eb_buf2.sv
// Two-slot landing buffer: slots fill at wp, drain from rp, occ tracks how many are held.
module eb_buf2
    import eb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output occ_t             occ,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] slot [2];
    logic             wp;
    logic             rp;

    // Pointers toggle freely; the caller guarantees no write into a full buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            occ     <= '0;
        end else begin
            if (wr_en) begin
                slot[wp] <= wr_data;
                wp       <= ~wp;
            end
            if (rd_en) begin
                rp <= ~rp;
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign rd_data = slot[rp];

endmodule

// File: rtl/eb_fifo_rd_stage.sv
// FIFO read-side stage: credit-based read issue into a 2-slot landing buffer that hides RAM latency.
module eb_fifo_rd_stage
    import eb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_0_req,
    output logic             t_0_ack,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             i_0_req,
    output logic [WIDTH-1:0] i_0_data,
    input  logic             i_0_ack
);

    occ_t occ;
    occ_t credit_used;
    logic infl;
    logic issue;
    logic pop;

    assign pop         = i_0_req && i_0_ack;
    assign credit_used = occ + occ_t'(infl);

    // A full buffer may still accept a read when a pop frees a slot in the same cycle.
    assign t_0_ack = (credit_used < occ_t'(EB_RD_DEPTH)) ||
                     ((credit_used == occ_t'(EB_RD_DEPTH)) && pop);
    assign issue   = t_0_req && t_0_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            infl <= 1'b0;
        end else begin
            infl <= issue;
        end
    end

    eb_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (infl),
        .wr_data (ram_rdata),
        .rd_en   (pop),
        .occ     (occ),
        .rd_data (i_0_data)
    );

    assign i_0_req = (occ != 2'd0);

endmodule
